// File: rtl/btn_pkg.sv
// btn_pkg: shared repeat-state encoding, default timings and helpers for the button conditioner.
package btn_pkg;
  typedef enum logic [1:0] {IDLE, DELAY, RPT} rpt_state_e;
  localparam int CLK_HZ = 50000000;
  localparam int DB_MS = 20;
  localparam int DB_CYCLES_DEF = CLK_HZ / 1000 * DB_MS;
  localparam int REPEAT_DELAY_DEF = 25000000;
  localparam int REPEAT_PERIOD_DEF = 5000000;
  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/btn_db_channel.sv
// btn_db_channel: one button bit -- synchroniser, two-way debounce, edge pulses and auto-repeat.
module btn_db_channel
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = DB_CYCLES_DEF,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic CLK,
  input  logic nrst,
  input  logic btn,
  output logic db_btn,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse
);
  localparam int DW = $clog2(DB_CYCLES);
  localparam int RW = $clog2(imax(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [DW-1:0] DB_MAX = DW'(DB_CYCLES - 1);
  localparam logic [RW-1:0] RD_MAX = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RP_MAX = RW'(REPEAT_PERIOD - 1);
  logic [SYNC_STAGES-1:0] sync;
  logic [DW-1:0] dcnt;
  logic [RW-1:0] rcnt;
  rpt_state_e st;
  logic s, fire, rise, fall;
  assign s = sync[SYNC_STAGES-1];
  assign fire = (s != db_btn) && (dcnt == DB_MAX);
  assign rise = fire && s;
  assign fall = fire && !s;
  // Repeat FSM reacts on the same edge the debounced level changes, so the
  // first repeat lands exactly REPEAT_DELAY cycles after press_pulse.
  always_ff @(posedge CLK) begin
    if (!nrst) begin
      sync <= '0;
      dcnt <= '0;
      db_btn <= 1'b0;
      press_pulse <= 1'b0;
      release_pulse <= 1'b0;
      repeat_pulse <= 1'b0;
      rcnt <= '0;
      st <= IDLE;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], btn};
      dcnt <= (s == db_btn || fire) ? '0 : dcnt + 1'b1;
      db_btn <= fire ? s : db_btn;
      press_pulse <= rise;
      release_pulse <= fall;
      repeat_pulse <= 1'b0;
      if (REPEAT_EN == 0 || fall) begin
        st <= IDLE;
        rcnt <= '0;
      end else if (rise) begin
        st <= DELAY;
        rcnt <= '0;
      end else begin
        case (st)
          DELAY: begin
            rcnt <= (rcnt == RD_MAX) ? '0 : rcnt + 1'b1;
            repeat_pulse <= (rcnt == RD_MAX);
            st <= (rcnt == RD_MAX) ? RPT : DELAY;
          end
          RPT: begin
            rcnt <= (rcnt == RP_MAX) ? '0 : rcnt + 1'b1;
            repeat_pulse <= (rcnt == RP_MAX);
          end
          default: rcnt <= '0;
        endcase
      end
    end
  end
endmodule

// File: rtl/btn_debounce_multi.sv
// btn_debounce_multi: N independent button conditioners side by side.
module btn_debounce_multi
  import btn_pkg::*;
#(
  parameter int N_BTN         = 4,
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = DB_CYCLES_DEF,
  parameter int REPEAT_EN     = 1,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic             CLK,
  input  logic             nrst,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] db_btn,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] repeat_pulse
);
  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    btn_db_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .DB_CYCLES(DB_CYCLES),
      .REPEAT_EN(REPEAT_EN),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_ch (
      .CLK(CLK),
      .nrst(nrst),
      .btn(btn[g]),
      .db_btn(db_btn[g]),
      .press_pulse(press_pulse[g]),
      .release_pulse(release_pulse[g]),
      .repeat_pulse(repeat_pulse[g])
    );
  end
endmodule

// File: tb/tb_btn_debounce_multi.sv
// tb_btn_debounce_multi: directed literal checks plus random stimulus against a sample-window model.
module tb_btn_debounce_multi;
  localparam int DB = 4, RD = 8, RP = 3;
  logic CLK = 0, nrst = 0;
  logic [3:0] btn = '0;
  logic [3:0] db, pr, rl, rp, db2, pr2, rl2, rp2;
  int npass = 0, ntot = 0, t = 0;
  logic [3:0] m_db = '0, m_pr = '0, m_rl = '0, m_rp = '0, held = '0, s_cur;
  logic [3:0] bq[$] = '{4'h0, 4'h0};
  bit hq[4][$];
  int pst[4];
  bit all_diff;

  always #5 CLK = ~CLK;

  btn_debounce_multi #(.N_BTN(4), .SYNC_STAGES(2), .DB_CYCLES(DB), .REPEAT_EN(1),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_dut (.CLK(CLK), .nrst(nrst), .btn(btn),
    .db_btn(db), .press_pulse(pr), .release_pulse(rl), .repeat_pulse(rp));
  btn_debounce_multi #(.N_BTN(4), .SYNC_STAGES(2), .DB_CYCLES(DB), .REPEAT_EN(0),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) u_dut_nr (.CLK(CLK), .nrst(nrst), .btn(btn),
    .db_btn(db2), .press_pulse(pr2), .release_pulse(rl2), .repeat_pulse(rp2));

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    ntot++;
    if (act === exp) npass++;
    else $display("FAIL %s at %0t: got %b expected %b", nm, $time, act, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // db flips once the last DB synchronised samples since the previous change all disagree with it
  always @(posedge CLK) begin
    t++;
    {m_pr, m_rl, m_rp} = '0;
    if (!nrst) begin
      m_db = '0;
      held = '0;
      bq = '{4'h0, 4'h0};
      for (int i = 0; i < 4; i++) hq[i].delete();
    end else begin
      s_cur = bq.pop_front();
      bq.push_back(btn);
      for (int i = 0; i < 4; i++) begin
        hq[i].push_back(s_cur[i]);
        if (hq[i].size() > DB) void'(hq[i].pop_front());
        all_diff = (hq[i].size() == DB);
        for (int j = 0; j < hq[i].size(); j++) if (hq[i][j] == m_db[i]) all_diff = 0;
        if (all_diff) begin
          m_db[i] = s_cur[i];
          hq[i].delete();
          held[i] = s_cur[i];
          m_pr[i] = s_cur[i];
          m_rl[i] = !s_cur[i];
          if (s_cur[i]) pst[i] = t;
        end
        if (held[i] && !m_pr[i] && t - pst[i] >= RD && (t - pst[i] - RD) % RP == 0) m_rp[i] = 1'b1;
      end
    end
    #1;
    chk("db_btn", db, m_db);
    chk("press_pulse", pr, m_pr);
    chk("release_pulse", rl, m_rl);
    chk("repeat_pulse", rp, m_rp);
    chk("norpt_db_btn", db2, m_db);
    chk("norpt_press", pr2, m_pr);
    chk("norpt_release", rl2, m_rl);
    chk("norpt_repeat_zero", rp2, 4'h0);
  end

  initial begin
    int pf;
    btn = 4'hF;
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk("rst_db", db, 4'h0);
      chk("rst_pulses", pr | rl | rp, 4'h0);
    end
    nrst = 1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (k == 5) chk("rst_rel_db5", db, 4'h0);
      if (k == 6) chk("rst_rel_db6", db, 4'hF);
      if (k == 6) chk("rst_rel_press6", pr, 4'hF);
      if (k == 7) chk("rst_rel_press7", pr, 4'h0);
      if (k == 13) chk("rpt_early", rp, 4'h0);
      if (k == 14) chk("rpt_first", rp, 4'hF);
    end
    btn = 4'h0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) chk("rpt_period", rp, 4'hF);
      if (k == 6) chk("rel_all", rl, 4'hF);
      if (k == 6) chk("rel_no_rpt", rp, 4'h0);
    end
    ticks(10);
    btn = 4'b0001;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 5) chk("clean_press5", pr, 4'h0);
      if (k == 6) chk("clean_press6", pr, 4'b0001);
      if (k == 6) chk("clean_db6", db, 4'b0001);
      if (k == 7) chk("clean_press7", pr, 4'h0);
    end
    btn = 4'h0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 6) chk("clean_release", rl, 4'b0001);
    end
    ticks(4);
    btn = 4'b0010;
    ticks(3);
    btn = 4'b0000;
    ticks(1);
    btn = 4'b0010;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) chk("bounce_press5", pr, 4'h0);
      if (k == 6) chk("bounce_press6", pr, 4'b0010);
    end
    ticks(10);
    btn = 4'b0000;
    ticks(3);
    btn = 4'b0010;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk("glitch_no_release", rl, 4'h0);
    end
    btn = 4'b0010;
    ticks(10);
    btn = 4'b1001;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 6) chk("simul_press", pr, 4'b1001);
      if (k == 6) chk("simul_release", rl, 4'b0010);
    end
    ticks(2);
    btn = 4'b0000;
    ticks(10);
    btn = 4'b0100;
    ticks(15);
    btn = 4'b0101;
    ticks(4);
    nrst = 0;
    tick();
    chk("mid_rst_db", db, 4'h0);
    chk("mid_rst_pulses", pr | rl | rp, 4'h0);
    nrst = 1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 5) chk("mid_rst_db5", db, 4'h0);
      if (k == 6) chk("mid_rst_press", pr, 4'b0101);
      if (k == 6) chk("mid_rst_db6", db, 4'b0101);
    end
    for (int seg = 0; seg < 15; seg++) begin
      pf = (seg % 3 == 0) ? 3 : (seg % 3 == 1) ? 12 : 50;
      for (int c = 0; c < 200; c++) begin
        for (int i = 0; i < 4; i++) if ($urandom_range(0, pf - 1) == 0) btn[i] = ~btn[i];
        nrst = ($urandom_range(0, 299) != 0);
        tick();
      end
    end
    nrst = 1;
    ticks(5);
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
